seven_seg_scan: RTL
===================

Name: seven_seg_scan

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It decodes full hex (0-F) per digit and supports per-digit enable, decimal points, optional leading-zero blanking and anti-ghosting dead-time. Display values are double-buffered so digits update only at frame boundaries, with no tearing. It sits between the car-control status logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1-8)
CLK_DIV, 50000, clk cycles per digit slot (digit period); must be > BLANK_CYCLES+1
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (dead-time)
SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: lit = 1
AN_ACTIVE_LOW, 1, 1: anode selected = 0; 0: selected = 1
LZ_BLANK, 0, 1: suppress leading zero digits

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  display enable; 0 blanks all outputs
value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = LS)
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark
load  in  1  one-cycle strobe; capture value/dp_in/digit_en into staging
seg  out  8  segments {a,b,c,d,e,f,g,dp}, seg[7]=a, seg[0]=dp
an  out  NUM_DIGITS  digit select, one-hot (polarity per AN_ACTIVE_LOW)
scan_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently in slot
frame_done  out  1  one-cycle pulse on last cycle of digit NUM_DIGITS-1

Behaviour:
- Reset (rst=1 at clk edge): div_cnt=0, scan_idx=0, staging=0, shadow=0, pending=0, seg=all unlit (8'hFF if active-low), an=all deselected, frame_done=0. Reset mid-slot aborts the slot; the next slot starts at digit 0, BLANK phase.
- Slot counter: div_cnt counts 0..CLK_DIV-1, wraps to 0 and increments scan_idx (NUM_DIGITS-1 wraps to 0). Counting continues regardless of en.
- Per slot: BLANK phase div_cnt<BLANK_CYCLES: an all deselected, seg unlit. ON phase: an selects scan_idx, seg = decode of shadow digit.
- seg/an registered: reflect div_cnt/scan_idx of previous cycle (1-cycle latency). frame_done is combinational from state: high when scan_idx=NUM_DIGITS-1 and div_cnt=CLK_DIV-1.
- Decode (active-low form; inverted when SEG_ACTIVE_LOW=0), bits a..g then dp: 0 0000001x,1 1001111x,2 0010010x,3 0000110x,4 1001100x,5 0100100x,6 0100000x,7 0001101x,8 0000000x,9 0000100x,A 0001000x,b 1100000x,C 0110001x,d 1000010x,E 0110000x,F 0111000x; x = dp: lit when shadow dp bit=1. All 16 codes defined; no latch/undefined output.
- Digit dark (a..g and dp unlit, anode still scanned) when: shadow digit_en[k]=0, or LZ_BLANK=1 and k>0 and digits k..NUM_DIGITS-1 all zero and dp[k]=0. Digit 0 never LZ-blanked.
- en=0: seg unlit, an deselected from next cycle; shadow/staging still update.
- Double buffer: load -> staging<=inputs, pending<=1. At frame_done cycle: if load same cycle, shadow<=inputs directly (bypass), pending<=0; else if pending, shadow<=staging, pending<=0. Multiple loads in one frame: last wins.

Test Plan:
- NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2; reset, load value=16'h1234, digit_en=4'hF, dp=0 -> display dark until first frame_done (cycle 31), then digit0 seg=8'b10011001 an=4'b1110, digit1 8'b00001101 an=4'b1101, digit2 8'b00100101, digit3 8'b10011111; an all 1 for 2 cycles per slot.
- Load 16'hABCD then 16'hFE00 same frame -> after frame_done digits 0..3 show 0,0,E,F (8'b00000011,8'b00000011,8'b01100001,8'b01110001); A-D never shown.
- load 16'h5555 asserted on frame_done cycle -> 5 (8'b01001001) on all digits from next slot; pending=0.
- LZ_BLANK=1, value=16'h0070, dp=4'b0100 -> digit3 dark, digit2 seg=8'b00000010 (0 with dp), digit1 8'b00011011, digit0 8'b00000011.
- digit_en=4'b1010, dp=4'b0001 -> digits 0,2 all segments 1 (including dp) while their anode still pulses; digits 1,3 normal.
- en=0 mid-slot -> next cycle seg=8'hFF, an=4'hF; rst mid-slot -> scan_idx=0, div_cnt=0, shadow=0, frame_done low.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: hex decode, dead-time, leading-zero
// blanking, and a staging/shadow buffer that swaps only at frame boundaries.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b0,
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CW = $clog2(CLK_DIV)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SW-1:0]           scan_idx,
    output logic                    frame_done
);

    localparam logic [7:0]            SEG_UNLIT = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [CW-1:0]                   div_cnt;
    logic [NUM_DIGITS-1:0][3:0]      stg_val, shd_val;
    logic [NUM_DIGITS-1:0]           stg_dp, stg_en, shd_dp, shd_en;
    logic                            pending;

    logic [NUM_DIGITS-1:0]           lz_dark;
    logic                            hi_zero;
    logic [3:0]                      nib;
    logic                            dark, blank;
    logic [7:0]                      seg_al;
    logic [NUM_DIGITS-1:0]           an_al;
    logic                            slot_end;

    // Active-low abcdefg pattern for one hex nibble.
    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: dec7 = 7'b0000001;
            4'h1: dec7 = 7'b1001111;
            4'h2: dec7 = 7'b0010010;
            4'h3: dec7 = 7'b0000110;
            4'h4: dec7 = 7'b1001100;
            4'h5: dec7 = 7'b0100100;
            4'h6: dec7 = 7'b0100000;
            4'h7: dec7 = 7'b0001101;
            4'h8: dec7 = 7'b0000000;
            4'h9: dec7 = 7'b0000100;
            4'hA: dec7 = 7'b0001000;
            4'hB: dec7 = 7'b1100000;
            4'hC: dec7 = 7'b0110001;
            4'hD: dec7 = 7'b1000010;
            4'hE: dec7 = 7'b0110000;
            default: dec7 = 7'b0111000;
        endcase
    endfunction

    assign slot_end   = (div_cnt == CW'(CLK_DIV - 1));
    assign frame_done = slot_end && (scan_idx == SW'(NUM_DIGITS - 1));

    // A digit is leading-zero blanked when it and every more-significant digit are zero.
    always_comb begin
        hi_zero = 1'b1;
        lz_dark = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (shd_val[k] == 4'h0);
            if (LZ_BLANK && k > 0 && hi_zero && !shd_dp[k])
                lz_dark[k] = 1'b1;
        end
    end

    always_comb begin
        nib    = shd_val[scan_idx];
        dark   = !shd_en[scan_idx] || lz_dark[scan_idx];
        blank  = !en || (32'(div_cnt) < BLANK_CYCLES);
        seg_al = 8'hFF;
        an_al  = {NUM_DIGITS{1'b1}};
        if (!blank) begin
            an_al[scan_idx] = 1'b0;
            if (!dark)
                seg_al = {dec7(nib), ~shd_dp[scan_idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            stg_val  <= '0;
            stg_dp   <= '0;
            stg_en   <= '0;
            shd_val  <= '0;
            shd_dp   <= '0;
            shd_en   <= '0;
            pending  <= 1'b0;
            seg      <= SEG_UNLIT;
            an       <= AN_OFF;
        end else begin
            if (slot_end) begin
                div_cnt  <= '0;
                scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                div_cnt  <= div_cnt + 1'b1;
            end

            if (load) begin
                stg_val <= value;
                stg_dp  <= dp_in;
                stg_en  <= digit_en;
                pending <= 1'b1;
            end
            // A load coinciding with the frame boundary bypasses staging.
            if (frame_done) begin
                pending <= 1'b0;
                if (load) begin
                    shd_val <= value;
                    shd_dp  <= dp_in;
                    shd_en  <= digit_en;
                end else if (pending) begin
                    shd_val <= stg_val;
                    shd_dp  <= stg_dp;
                    shd_en  <= stg_en;
                end
            end

            seg <= SEG_ACTIVE_LOW ? seg_al : ~seg_al;
            an  <= AN_ACTIVE_LOW ? an_al : ~an_al;
        end
    end

endmodule
